// File: rtl/exp_pkg.sv
// exp_pkg: shared fixed-point widths and FSM state encoding for the exp datapath
package exp_pkg;
  localparam int Q7_25_W    = 32;
  localparam int Q7_25_FRAC = 25;
  localparam int Q2_14_W    = 16;
  localparam int Q2_14_FRAC = 14;
  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;
endpackage

// File: rtl/exp_sum_accum_if.sv
// exp_sum_accum_if: sample-in / sum-out handshake bundle for exp_sum_accum
// Signals: i_valid, i_data, o_ready (sample side); o_valid, i_ready, o_sum, o_ovf (sum side).
// master drives samples and i_ready; slave is the accumulator.
interface exp_sum_accum_if #(
  parameter int WIDTHIN = 32,
  parameter int ACC_W   = 40
);
  logic               i_valid;
  logic               o_ready;
  logic [WIDTHIN-1:0] i_data;
  logic               o_valid;
  logic               i_ready;
  logic [ACC_W-1:0]   o_sum;
  logic               o_ovf;
  modport master (output i_valid, i_data, i_ready, input o_ready, o_valid, o_sum, o_ovf);
  modport slave  (input i_valid, i_data, i_ready, output o_ready, o_valid, o_sum, o_ovf);
endinterface

// File: rtl/exp_sat_add.sv
// exp_sat_add: W-bit unsigned add with carry-out, wrapping or saturating
// Ports: a_i, b_i addends; s_o sum; c_o carry out of W bits.
// Macro EXP_SUM_SATURATE_EN: defined clamps s_o to all-ones on carry, undefined wraps.
module exp_sat_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  logic [W:0] full;
  assign full = {1'b0, a_i} + {1'b0, b_i};
  assign c_o  = full[W];
`ifdef EXP_SUM_SATURATE_EN
  assign s_o = c_o ? '1 : full[W-1:0];
`else
  assign s_o = full[W-1:0];
`endif
endmodule

// File: rtl/exp_sum_accum.sv
// exp_sum_accum: sums FRAME_LEN Q7.25 exp samples into one Q(ACC_W-25).25 frame sum
// Ports: clk; reset (async, active-high); bus (slave): i_valid/o_ready/i_data accept samples,
//   o_valid/i_ready/o_sum/o_ovf present the frame sum and sticky overflow flag.
// Overflow handling (wrap or clamp) is selected by EXP_SUM_SATURATE_EN inside exp_sat_add.
module exp_sum_accum
  import exp_pkg::*;
#(
  parameter int WIDTHIN   = Q7_25_W,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 16
) (
  input logic            clk,
  input logic            reset,
  exp_sum_accum_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, add_s, din;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, add_c, last;
  assign din  = {{(ACC_W-WIDTHIN){1'b0}}, bus.i_data};
  assign last = cnt_q == CNT_W'(FRAME_LEN - 1);
  exp_sat_add #(.W(ACC_W)) u_add (.a_i(acc_q), .b_i(din), .s_o(add_s), .c_o(add_c));
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (state_q == DONE) begin
      if (bus.i_ready) begin
        state_d = ACCUM;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end
    end else if (bus.i_valid) begin
      acc_d   = add_s;
      ovf_d   = ovf_q | add_c;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? DONE : ACCUM;
      sum_d   = last ? add_s : sum_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.o_ready = state_q == ACCUM;
  assign bus.o_valid = state_q == DONE;
  assign bus.o_sum   = sum_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_exp_sum_accum.sv
// tb_exp_sum_accum: directed and random frames against a frame-sum reference model
module tb_exp_sum_accum;
  localparam int AW = 33;
  localparam logic [63:0] MAX = (64'd1 << AW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] smp [4];
  int gap [4];
  logic [31:0] v;
  exp_sum_accum_if #(.WIDTHIN(32), .ACC_W(AW)) a ();
  exp_sum_accum_if #(.WIDTHIN(32), .ACC_W(40)) b ();
  exp_sum_accum #(.WIDTHIN(32), .ACC_W(AW), .FRAME_LEN(4)) u_a (.clk(clk), .reset(reset), .bus(a));
  exp_sum_accum #(.WIDTHIN(32), .ACC_W(40), .FRAME_LEN(1)) u_b (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  function automatic logic [63:0] exp_sum(input longint unsigned t);
`ifdef EXP_SUM_SATURATE_EN
    return (t > MAX) ? MAX : t;
`else
    return t & MAX;
`endif
  endfunction
  task automatic frame4(input int hold);
    longint unsigned tot = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (gap[k]) begin
        a.i_valid = 1'b0;
        a.i_data = $urandom;
        cyc();
        chk("gap_vld", a.o_valid, 0);
        chk("gap_rdy", a.o_ready, 1);
      end
      chk("acc_rdy", a.o_ready, 1);
      a.i_valid = 1'b1;
      a.i_data = smp[k];
      tot += smp[k];
      cyc();
      if (k < 3) chk("acc_vld", a.o_valid, 0);
    end
    a.i_valid = 1'b1;
    a.i_data = $urandom;
    a.i_ready = 1'b0;
    chk("done_vld", a.o_valid, 1);
    chk("done_rdy", a.o_ready, 0);
    chk("done_sum", a.o_sum, exp_sum(tot));
    chk("done_ovf", a.o_ovf, {63'd0, tot > MAX});
    repeat (hold) begin
      cyc();
      chk("hold_vld", a.o_valid, 1);
      chk("hold_rdy", a.o_ready, 0);
      chk("hold_sum", a.o_sum, exp_sum(tot));
      chk("hold_ovf", a.o_ovf, {63'd0, tot > MAX});
    end
    a.i_ready = 1'b1;
    cyc();
    a.i_ready = 1'b0;
    a.i_valid = 1'b0;
    chk("rel_vld", a.o_valid, 0);
    chk("rel_rdy", a.o_ready, 1);
    chk("rel_ovf", a.o_ovf, 0);
  endtask
  initial begin
    a.i_valid = 1'b0; a.i_data = '0; a.i_ready = 1'b0;
    b.i_valid = 1'b0; b.i_data = '0; b.i_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_rdy", a.o_ready, 1);
    chk("rst_vld", a.o_valid, 0);
    chk("rst_sum", a.o_sum, 0);
    chk("rst_ovf", a.o_ovf, 0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin smp[k] = 32'h0200_0000; gap[k] = 0; end
    frame4(0);
    frame4(5);
    for (int k = 0; k < 4; k++) smp[k] = 32'hFFFF_FFFF;
    frame4(1);
    a.i_valid = 1'b1;
    a.i_data = 32'h0200_0000;
    cyc();
    cyc();
    a.i_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("mid_rst_sum", a.o_sum, 0);
    chk("mid_rst_ovf", a.o_ovf, 0);
    chk("mid_rst_rdy", a.o_ready, 1);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) smp[k] = 32'h0200_0000;
    frame4(0);
    for (int k = 0; k < 4; k++) smp[k] = 32'h0100_0000;
    gap[0] = 0; gap[1] = 2; gap[2] = 0; gap[3] = 1;
    frame4(0);
    repeat (20) begin
      for (int k = 0; k < 4; k++) begin
        smp[k] = $urandom >> $urandom_range(4, 0);
        gap[k] = $urandom_range(2, 0);
      end
      frame4($urandom_range(3, 0));
    end
    b.i_ready = 1'b1;
    for (int x = 1; x <= 6; x++) begin
      v = (x <= 3) ? 32'(x) : $urandom;
      b.i_valid = 1'b1;
      b.i_data = v;
      chk("f1_rdy", b.o_ready, 1);
      cyc();
      chk("f1_vld", b.o_valid, 1);
      chk("f1_sum", b.o_sum, {32'd0, v});
      chk("f1_busy", b.o_ready, 0);
      chk("f1_ovf", b.o_ovf, 0);
      cyc();
      chk("f1_rel_vld", b.o_valid, 0);
      chk("f1_rel_rdy", b.o_ready, 1);
    end
    b.i_ready = 1'b0;
    b.i_data = 32'h5;
    cyc();
    b.i_valid = 1'b0;
    chk("f1_pend_vld", b.o_valid, 1);
    reset = 1'b1;
    #2;
    chk("done_rst_vld", b.o_valid, 0);
    chk("done_rst_sum", b.o_sum, 0);
    chk("done_rst_rdy", b.o_ready, 1);
    cyc();
    reset = 1'b0;
    cyc();
    chk("done_rst_idle", b.o_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
